// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle RV32M divide/remainder unit for the EX stage. It holds the
// front of the pipeline (stall) while a single restoring-divide datapath
// retires one quotient bit per cycle, then pulses done for one cycle with the
// result and the exception-style flags so EX/MEM can capture them as the
// pipeline is released.
//
// Parameters
//   XLEN   operand/result width in bits
//   CNT_W  iteration counter width, 2**CNT_W > XLEN
//
// Ports
//   CLK                  in   clock, rising edge
//   RESET                in   synchronous active-high reset
//   start                in   EX holds a valid divide-class instruction
//   op[1:0]              in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend[XLEN-1:0]   in   rs1 operand
//   divisor[XLEN-1:0]    in   rs2 operand
//   flush                in   kill the in-flight op (redirect)
//   stall                out  hold IF/ID/EX (combinational)
//   done                 out  one-cycle pulse, result and flags valid
//   result[XLEN-1:0]     out  quotient (DIV/DIVU) or remainder (REM/REMU)
//   zero_division        out  divisor was zero, valid with done
//   overflow_signed_div  out  signed most-negative / -1, valid with done
// ---------------------------------------------------------------------------
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero_division,
  output logic            overflow_signed_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  // Magnitude of a two's-complement value; the most negative value maps to
  // itself, which read as unsigned is exactly its magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    logic signed [XLEN-1:0] neg_v;
    neg_v = -v;
    return v[XLEN-1] ? neg_v : v;
  endfunction

  // Conditional two's-complement negation used for the final sign fix-up.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              is_signed;
  logic              div_zero;
  logic              sgn_ovf;
  logic              special;
  logic              last_step;

  // Iteration state: rem_q is the partial remainder; quo_q starts as the
  // dividend magnitude and is shifted left each step, its MSB feeding the
  // remainder while the new quotient bit enters at the LSB.
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvs_q;
  logic              op_rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              zd_q;
  logic              ovf_q;

  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  assign is_signed = ~op[0];
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = is_signed & (dividend == SMIN) & (divisor == '1);
  assign special   = div_zero | sgn_ovf;
  assign accept    = (state_q == IDLE) & start & ~flush;
  assign last_step = (cnt_q == CNT_W'(XLEN-1));

  // The partial remainder is always below the divisor, so the shifted value
  // is below 2*divisor and the XLEN+1-bit difference is negative (MSB set)
  // exactly when the divisor does not fit.
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};

  // ---- state register ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    stall               = accept | (state_q == CALC);
    done                = (state_q == DONE) & ~flush;
    zero_division       = zd_q & done;
    overflow_signed_div = ovf_q & done;
  end

  // ---- iteration counter ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---- operand capture and restoring step ----
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_rem_q  <= op[1];
      neg_quo_q <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_rem_q <= is_signed & dividend[XLEN-1];
      quo_q     <= is_signed ? abs_val(dividend) : dividend;
      dvs_q     <= is_signed ? abs_val(divisor) : divisor;
      rem_q     <= '0;
    end else if (state_q == CALC) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

  // ---- result and flag capture on entry to DONE ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      result <= '0;
      zd_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept & special) begin
      if (div_zero) begin
        result <= op[1] ? dividend : '1;
      end else begin
        result <= op[1] ? '0 : SMIN;
      end
      zd_q  <= div_zero;
      ovf_q <= ~div_zero;
    end else if ((state_q == CALC) & last_step & ~flush) begin
      result <= op_rem_q ? cond_neg(rem_next, neg_rem_q)
                         : cond_neg(quo_next, neg_quo_q);
      zd_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle integer divide/remainder sequencer for the EX stage. It handles RV32M DIV/DIVU/REM/REMU. It stalls the front of the pipeline while it iterates and produces the result and the exception-style flags `zero_division` and `overflow_signed_div`. The EX/MEM pipeline register captures these in the cycle the pipeline is released. It owns a single shared restoring-divide datapath (one quotient bit per cycle).

Parameters:
- XLEN, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  EX holds a valid divide-class instruction; held stable by the stall until done.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- dividend  input  XLEN  rs1 operand.
- divisor  input  XLEN  rs2 operand.
- flush  input  1  kill the in-flight op (branch/jump redirect).
- stall  output  1  hold IF/ID/EX; EX/MEM receives a bubble.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- zero_division  output  1  divisor was 0; valid with done.
- overflow_signed_div  output  1  signed op with 0x80000000 / -1; valid with done.

Behaviour:
- Reset (RESET=1 at an edge):
  - state=IDLE, counter=0.
  - result=0, done=0, zero_division=0, overflow_signed_div=0.
  - Reset has priority over flush and start and aborts any op mid-flight.
- States:
  - IDLE: if start & !flush, latch op and operands, then:
    - divisor==0 → DONE with special result.
    - Signed op with dividend==0x80000000 and divisor==0xFFFFFFFF → DONE with overflow result.
    - Otherwise → CALC with counter=0.
  - CALC: one restoring step per cycle on absolute values (signed ops) or raw values (unsigned ops):
    - Shift remainder left, bringing in the next dividend bit MSB-first.
    - Subtract the divisor; if the difference is non-negative, keep it and set the quotient bit to 1.
    - counter increments each step; after step XLEN-1 (counter==XLEN-1) → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE. start is ignored in DONE (the instruction is leaving EX).
- stall (combinational):
  - 1 when (state==IDLE & start & !flush) or state==CALC.
  - 0 in DONE, so the pipeline advances and EX/MEM captures the result that cycle.
- Latency, measured from the cycle start is first seen in IDLE:
  - Normal op: stall high for XLEN+1 cycles (1 IDLE + XLEN CALC); done at cycle XLEN+1 = 33.
  - Special case: stall high 1 cycle; done at cycle 1.
- Sign fix-up, applied on entering DONE:
  - DIV: quotient is negated if the operand signs differ.
  - REM: remainder takes the sign of the dividend.
- Special results:
  - Divide by zero: quotient=all-ones; remainder=dividend; zero_division=1.
  - Signed overflow: quotient=0x80000000; remainder=0; overflow_signed_div=1.
  - Flags are 0 in every other case and are valid only while done=1; they are 0 otherwise.
- result holds its last value outside DONE; consumers qualify it with done.
- flush:
  - In CALC or DONE: next state is IDLE, no done pulse, flags stay 0.
  - In IDLE: start is not accepted that cycle and stall=0.
- start with flush in the same cycle: flush wins.
- Back-to-back divides: a new start is accepted in the cycle after DONE (IDLE). There is no dead cycle beyond the DONE cycle.
- All arithmetic uses XLEN+1-bit intermediates for the subtract. Absolute value of 0x80000000 is 0x80000000 interpreted unsigned.

Test Plan:
- DIV 100/7: start at cycle 0 → stall high cycles 0–32, done at cycle 33, result=14 (0x0000000E), both flags 0.
- REM -100 (0xFFFFFF9C) / 7 → result=0xFFFFFFFE (-2). DIVU 0xFFFFFFFF/2 → result=0x7FFFFFFF.
- DIVU 5/0 → done at cycle 1, result=0xFFFFFFFF, zero_division=1. REMU 5/0 → result=5, zero_division=1.
- DIV 0x80000000 / 0xFFFFFFFF → done at cycle 1, result=0x80000000, overflow_signed_div=1. REM with the same operands → result=0.
- flush at cycle 10 of CALC → state IDLE at cycle 11, stall=0, no done pulse. A new DIV 9/3 issued afterwards → result=3.
- RESET asserted at cycle 20 of CALC → next cycle all outputs 0, state IDLE. Back-to-back DIVs give two done pulses exactly 34 cycles apart.
